// File: rtl/usb_rx_pkg.sv
// Shared constants, types and PID decode for the USB receive timer.
package usb_rx_pkg;

    // Token, handshake and data PIDs (low nibble of the PID byte)
    localparam logic [3:0] PID_OUT   = 4'b0001;
    localparam logic [3:0] PID_IN    = 4'b1001;
    localparam logic [3:0] PID_SETUP = 4'b1101;
    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [3:0] PID_NAK   = 4'b1010;
    localparam logic [3:0] PID_STALL = 4'b1110;
    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_DATA1 = 4'b1011;

    // Packet lengths in bytes, PID byte included
    localparam int unsigned HS_LEN        = 1;
    localparam int unsigned TOKEN_LEN     = 3;
    localparam int unsigned CRC_BYTES     = 2;
    localparam int unsigned BITS_PER_BYTE = 8;

    typedef enum logic [1:0] {
        PktNone      = 2'd0,
        PktHandshake = 2'd1,
        PktToken     = 2'd2,
        PktData      = 2'd3
    } pkt_type_e;

    typedef enum logic [1:0] {
        StIdle,
        StPid,
        StBody,
        StError
    } state_e;

    // PktNone means the byte is not an acceptable PID (bad check nibble or unsupported code)
    function automatic pkt_type_e decode_pid(input logic [7:0] pid_byte);
        decode_pid = PktNone;
        if (pid_byte[7:4] == ~pid_byte[3:0]) begin
            case (pid_byte[3:0])
                PID_ACK, PID_NAK, PID_STALL: decode_pid = PktHandshake;
                PID_OUT, PID_IN, PID_SETUP:  decode_pid = PktToken;
                PID_DATA0, PID_DATA1:        decode_pid = PktData;
                default:                     decode_pid = PktNone;
            endcase
        end
    endfunction

endpackage

// File: rtl/flex_counter.sv
// Generic wrapping counter: counts 0..rollover_val-1 and emits a registered
// one-cycle rollover_flag in the cycle after the wrapping increment.
module flex_counter #(
    parameter int unsigned NUM_CNT_BITS = 4
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    clear,
    input  logic                    count_enable,
    input  logic [NUM_CNT_BITS-1:0] rollover_val,
    output logic [NUM_CNT_BITS-1:0] count_out,
    output logic                    rollover_flag
);

    logic [NUM_CNT_BITS-1:0] count_q, count_d;
    logic                    flag_q, flag_d;

    // Next count: clear wins over enable; wrap to zero on the last value
    always_comb begin
        count_d = count_q;
        flag_d  = 1'b0;
        if (clear) begin
            count_d = '0;
        end else if (count_enable) begin
            if (count_q == rollover_val - NUM_CNT_BITS'(1)) begin
                count_d = '0;
                flag_d  = 1'b1;
            end else begin
                count_d = count_q + NUM_CNT_BITS'(1);
            end
        end
    end

    // Count and flag registers
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count_q <= '0;
            flag_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            flag_q  <= flag_d;
        end
    end

    assign count_out     = count_q;
    assign rollover_flag = flag_q;

endmodule

// File: rtl/usb_timer_rx.sv
// USB receive timing/framing: counts unstuffed bits into bytes, checks the PID,
// tracks packet length and validates the packet at EOP.
module usb_timer_rx
    import usb_rx_pkg::*;
#(
    parameter int unsigned PAYLOAD_BYTES = 32,
    parameter int unsigned CNT_W         = 6
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             receiving,
    input  logic             shift_enable,
    input  logic [7:0]       rx_byte,
    input  logic             eop,
    output logic             byte_received,
    output logic             packet_done,
    output logic             rx_error,
    output logic [3:0]       pid,
    output logic [1:0]       pkt_type,
    output logic [CNT_W-1:0] byte_count
);

    localparam logic [CNT_W-1:0] HsLen   = CNT_W'(HS_LEN);
    localparam logic [CNT_W-1:0] TokLen  = CNT_W'(TOKEN_LEN);
    localparam logic [CNT_W-1:0] DataLen = CNT_W'(1 + PAYLOAD_BYTES + CRC_BYTES);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] byte_count_q, byte_count_d;
    logic [CNT_W-1:0] expected_q, expected_d;
    logic [3:0]       pid_q, pid_d;
    pkt_type_e        pkt_type_q, pkt_type_d;
    logic             rx_error_q, rx_error_d;
    logic             packet_done_q, packet_done_d;

    logic             pkt_start, cnt_clear, cnt_en;
    logic [3:0]       bit_cnt;
    logic             byte_done;
    pkt_type_e        dec_type;
    logic [CNT_W-1:0] dec_len;
    logic [CNT_W-1:0] cnt_now, exp_now;
    logic             pkt_bad;

    assign pkt_start = (state_q == StIdle) && receiving;
    assign cnt_clear = !receiving || pkt_start;
    // A strobe coincident with eop belongs to the EOP, not the packet
    assign cnt_en    = shift_enable && !eop && (state_q != StIdle);

    flex_counter #(
        .NUM_CNT_BITS (4)
    ) u_bit_cnt (
        .clk           (clk),
        .n_rst         (n_rst),
        .clear         (cnt_clear),
        .count_enable  (cnt_en),
        .rollover_val  (4'(BITS_PER_BYTE)),
        .count_out     (bit_cnt),
        .rollover_flag (byte_done)
    );

    assign dec_type = decode_pid(rx_byte);

    // Expected total packet length for the PID currently on rx_byte
    always_comb begin
        dec_len = '0;
        unique case (dec_type)
            PktHandshake: dec_len = HsLen;
            PktToken:     dec_len = TokLen;
            PktData:      dec_len = DataLen;
            default:      dec_len = '0;
        endcase
    end

    // Framing FSM: a completed byte is accounted for before eop/abort are judged
    always_comb begin
        state_d       = state_q;
        byte_count_d  = byte_count_q;
        expected_d    = expected_q;
        pid_d         = pid_q;
        pkt_type_d    = pkt_type_q;
        rx_error_d    = rx_error_q;
        packet_done_d = 1'b0;
        pkt_bad       = 1'b0;
        exp_now       = expected_q;
        cnt_now       = byte_count_q;
        if (byte_done && (byte_count_q != {CNT_W{1'b1}})) begin
            cnt_now = byte_count_q + CNT_W'(1);
        end

        unique case (state_q)
            StIdle: begin
                if (receiving) begin
                    state_d      = StPid;
                    byte_count_d = '0;
                    expected_d   = '0;
                    pid_d        = '0;
                    pkt_type_d   = PktNone;
                    rx_error_d   = 1'b0;
                end
            end
            StPid, StBody: begin
                byte_count_d = cnt_now;
                if (state_q == StPid) begin
                    if (byte_done) begin
                        if (dec_type == PktNone) begin
                            pkt_bad = 1'b1;
                        end else begin
                            pid_d      = rx_byte[3:0];
                            pkt_type_d = dec_type;
                            expected_d = dec_len;
                            exp_now    = dec_len;
                            state_d    = StBody;
                        end
                    end
                end else if (byte_done && (cnt_now > expected_q)) begin
                    pkt_bad = 1'b1;
                end

                if (eop) begin
                    // Only a decoded packet can complete; the PID byte must be in
                    if (!pkt_bad && (state_d == StBody) && (cnt_now == exp_now) &&
                        (bit_cnt == '0)) begin
                        packet_done_d = 1'b1;
                        state_d       = StIdle;
                    end else begin
                        rx_error_d = 1'b1;
                        state_d    = StError;
                    end
                end else if (!receiving) begin
                    rx_error_d = 1'b1;
                    state_d    = StIdle;
                end else if (pkt_bad) begin
                    rx_error_d = 1'b1;
                    state_d    = StError;
                end
            end
            StError: begin
                byte_count_d = cnt_now;
                rx_error_d   = 1'b1;
                if (eop || !receiving) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q       <= StIdle;
            byte_count_q  <= '0;
            expected_q    <= '0;
            pid_q         <= '0;
            pkt_type_q    <= PktNone;
            rx_error_q    <= 1'b0;
            packet_done_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            byte_count_q  <= byte_count_d;
            expected_q    <= expected_d;
            pid_q         <= pid_d;
            pkt_type_q    <= pkt_type_d;
            rx_error_q    <= rx_error_d;
            packet_done_q <= packet_done_d;
        end
    end

    assign byte_received = byte_done;
    assign packet_done   = packet_done_q;
    assign rx_error      = rx_error_q;
    assign pid           = pid_q;
    assign pkt_type      = pkt_type_q;
    assign byte_count    = byte_count_q;

endmodule

// File: tb/tb_usb_timer_rx.sv
// Directed + randomized packet bench for usb_timer_rx with a packet-level reference model.
module tb_usb_timer_rx;

    localparam int unsigned PAYLOAD = 32;
    localparam int unsigned CW      = 6;

    logic          clk = 1'b0;
    logic          n_rst;
    logic          receiving, shift_enable, eop;
    logic [7:0]    rx_byte;
    logic          byte_received, packet_done, rx_error;
    logic [3:0]    pid;
    logic [1:0]    pkt_type;
    logic [CW-1:0] byte_count;

    int checks   = 0;
    int failures = 0;
    int br_total = 0;
    int pd_total = 0;

    usb_timer_rx #(
        .PAYLOAD_BYTES (PAYLOAD),
        .CNT_W         (CW)
    ) dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .receiving     (receiving),
        .shift_enable  (shift_enable),
        .rx_byte       (rx_byte),
        .eop           (eop),
        .byte_received (byte_received),
        .packet_done   (packet_done),
        .rx_error      (rx_error),
        .pid           (pid),
        .pkt_type      (pkt_type),
        .byte_count    (byte_count)
    );

    always #5 clk = ~clk;

    // Pulse tallies, sampled on the inactive edge
    always @(negedge clk) begin
        if (byte_received) br_total++;
        if (packet_done)   pd_total++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Packet-level outcome from bytes/bits seen and how the packet ended
    function automatic void model(input logic [7:0] b0, input int nbits, input bit has_eop,
                                  output bit err, output bit done,
                                  output logic [3:0] e_pid, output logic [1:0] e_type);
        int nbytes;
        int len;
        nbytes = nbits / 8;
        len    = 0;
        err    = 1'b0;
        e_pid  = 4'h0;
        e_type = 2'd0;
        if (nbytes >= 1) begin
            if (b0[7:4] != ~b0[3:0]) err = 1'b1;
            else begin
                case (b0[3:0])
                    4'b0010, 4'b1010, 4'b1110: begin e_type = 2'd1; len = 1; end
                    4'b0001, 4'b1001, 4'b1101: begin e_type = 2'd2; len = 3; end
                    4'b0011, 4'b1011:          begin e_type = 2'd3; len = 3 + PAYLOAD; end
                    default:                   err = 1'b1;
                endcase
            end
            if (!err) e_pid = b0[3:0];
            if (!err && nbytes > len) err = 1'b1;
        end
        if (!has_eop) err = 1'b1;
        else if (nbytes == 0 || nbytes != len || (nbits % 8) != 0) err = 1'b1;
        done = has_eop && !err;
    endfunction

    task automatic run_packet(input string tag, input logic [7:0] b0, input int nbits,
                              input bit has_eop, input bit coinc);
        bit         e_err, e_done;
        logic [3:0] e_pid;
        logic [1:0] e_type;
        int         br0, pd0;
        logic [7:0] cur;
        model(b0, nbits, has_eop, e_err, e_done, e_pid, e_type);
        cur = b0;

        receiving = 1'b1;
        step();
        check({tag, "/start"}, {rx_error, pid, pkt_type, byte_count}, 32'h0);
        br0 = br_total;
        pd0 = pd_total;

        for (int b = 0; b < nbits; b++) begin
            if (b % 8 == 0) cur = (b == 0) ? b0 : 8'($urandom);
            rx_byte      = cur;
            shift_enable = 1'b1;
            step();
            shift_enable = 1'b0;
            if (b % 8 == 7) check({tag, "/byte_pulse"}, byte_received, 1);
            if (b != nbits - 1) repeat ($urandom_range(1, 2)) step();
        end

        if (coinc) step();
        else repeat ($urandom_range(0, 2)) step();

        eop          = has_eop;
        shift_enable = has_eop & coinc;
        receiving    = 1'b0;
        step();
        eop          = 1'b0;
        shift_enable = 1'b0;
        check({tag, "/done"}, packet_done, e_done);
        check({tag, "/err"}, rx_error, e_err);

        repeat (3) step();
        check({tag, "/n_bytes"}, br_total - br0, nbits / 8);
        check({tag, "/n_done"}, pd_total - pd0, e_done);
        check({tag, "/pid"}, pid, e_pid);
        check({tag, "/type"}, pkt_type, e_type);
        check({tag, "/count"}, byte_count, nbits / 8);
        check({tag, "/err_hold"}, rx_error, e_err);
    endtask

    initial begin
        n_rst        = 1'b0;
        receiving    = 1'b0;
        shift_enable = 1'b0;
        eop          = 1'b0;
        rx_byte      = 8'h00;
        #1;
        check("reset", {byte_received, packet_done, rx_error, pid, pkt_type, byte_count}, 0);
        repeat (2) step();
        n_rst = 1'b1;
        step();

        run_packet("ack",        8'hD2, 8,   1'b1, 1'b0);
        run_packet("in",         8'h69, 24,  1'b1, 1'b0);
        run_packet("data0",      8'hC3, 8 * (3 + PAYLOAD), 1'b1, 1'b0);
        run_packet("bad_pid",    8'hC2, 8,   1'b1, 1'b0);
        run_packet("after_bad",  8'h5A, 8,   1'b1, 1'b0);
        run_packet("short_tok",  8'hE1, 16,  1'b1, 1'b0);
        run_packet("bits20",     8'h69, 20,  1'b1, 1'b0);
        run_packet("overrun",    8'h2D, 32,  1'b1, 1'b0);
        run_packet("abort_data", 8'h4B, 100, 1'b0, 1'b0);
        run_packet("ack_coinc",  8'hD2, 8,   1'b1, 1'b1);

        // Reset in the middle of a data packet
        receiving = 1'b1;
        step();
        for (int b = 0; b < 12; b++) begin
            rx_byte      = 8'hC3;
            shift_enable = 1'b1;
            step();
            shift_enable = 1'b0;
            step();
        end
        check("pre_rst_type", pkt_type, 3);
        check("pre_rst_count", byte_count, 1);
        n_rst = 1'b0;
        #1;
        check("mid_rst", {byte_received, packet_done, rx_error, pid, pkt_type, byte_count}, 0);
        step();
        receiving = 1'b0;
        n_rst     = 1'b1;
        repeat (2) step();
        check("post_rst", {byte_received, packet_done, rx_error, pid, pkt_type, byte_count}, 0);

        for (int i = 0; i < 30; i++) begin
            int         kind;
            int         len;
            int         nb;
            logic [7:0] b0;
            bit         he;
            bit         co;
            kind = $urandom_range(0, 8);
            case (kind)
                0: b0 = 8'hD2;
                1: b0 = 8'h5A;
                2: b0 = 8'h1E;
                3: b0 = 8'hE1;
                4: b0 = 8'h69;
                5: b0 = 8'h2D;
                6: b0 = 8'hC3;
                7: b0 = 8'h4B;
                default: b0 = 8'hC2;
            endcase
            len = (kind <= 2) ? 1 : (kind <= 5) ? 3 : (kind <= 7) ? 3 + PAYLOAD : 3;
            nb  = len * 8;
            case ($urandom_range(0, 6))
                0: nb = nb - 1;
                1: nb = nb + 3;
                2: nb = nb + 8;
                3: nb = nb - 8;
                default: nb = nb;
            endcase
            if (nb < 0) nb = 0;
            he = ($urandom_range(0, 9) != 0);
            co = he && ($urandom_range(0, 3) == 0);
            run_packet($sformatf("rnd%0d", i), b0, nb, he, co);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/usb_timer_rx.md
Name: usb_timer_rx

Overview:
Receive-side timing and framing controller for the USB packet path; the counterpart of the transmit timer.
- Counts valid (unstuffed) bit strobes from the receive shift path and pulses byte_received every 8 bits.
- Decodes and checks the PID from the first byte, selects the expected packet length, counts bytes, and validates against EOP.
- Sits between the NRZI-decode/bit-unstuff/shift-register front end and the receive FIFO/controller.

Parameters:
PAYLOAD_BYTES, 32, data-packet payload length in bytes (DATA0/DATA1 total = 1 + PAYLOAD_BYTES + 2 CRC)
CNT_W, 6, width of byte_count; must hold 3 + PAYLOAD_BYTES

Ports:
clk  in  1  system clock
n_rst  in  1  asynchronous active-low reset
receiving  in  1  high from sync detect until EOP/abort
shift_enable  in  1  one-cycle strobe per valid data bit; stuffed bits excluded; at least 2 cycles apart
rx_byte  in  8  assembled byte from shift register; stable until next shift_enable
eop  in  1  one-cycle end-of-packet strobe
byte_received  out  1  one-cycle pulse per completed byte
packet_done  out  1  one-cycle pulse on valid packet completion
rx_error  out  1  level; packet framing/PID error
pid  out  4  latched PID of current/last packet
pkt_type  out  2  0 none, 1 handshake, 2 token, 3 data
byte_count  out  CNT_W  bytes received in current packet (includes PID)

Behaviour:
- Clock is clk. Reset is asynchronous and active-low on n_rst. Reset state: IDLE, all outputs 0, bit counter 0.
- States: IDLE, PID, BODY, ERROR.
- IDLE -> PID on receiving=1. On entry, clear rx_error, byte_count, bit counter, pid and pkt_type.
- Bit counter (0..7) increments on shift_enable in PID/BODY. On the 8th bit it wraps to 0 and registers a byte-complete event. byte_received asserts exactly 1 cycle after the 8th shift_enable.
- In the byte_received cycle, byte_count increments by 1 and saturates at 2^CNT_W-1.
- PID state, byte_received cycle: check rx_byte[7:4] == ~rx_byte[3:0]. Failure -> ERROR. Otherwise latch pid = rx_byte[3:0] and decode it:
  - ACK 0010, NAK 1010, STALL 1110: pkt_type=1, expected=1
  - OUT 0001, IN 1001, SETUP 1101: pkt_type=2, expected=3
  - DATA0 0011, DATA1 1011: pkt_type=3, expected=3+PAYLOAD_BYTES
  - Any other PID -> ERROR.
  - Valid PID -> BODY.
- BODY: a byte_received that takes byte_count above expected (overrun) -> ERROR.
- eop in PID or BODY:
  - byte_count == expected and bit counter == 0 -> packet_done pulses 1 cycle later; go to IDLE.
  - Otherwise (short packet or partial byte) -> ERROR.
- eop and shift_enable in the same cycle: the bit is ignored and eop is evaluated on the prior counts.
- eop in the same cycle a byte completes internally: the byte is counted first, then eop is evaluated.
- receiving falls without eop in PID/BODY (abort): rx_error=1, go to IDLE.
- ERROR: rx_error=1 (level); byte_received still pulses; no packet_done. Leave ERROR to IDLE on eop or receiving=0. rx_error holds until the next packet start.
- pid, pkt_type and byte_count hold after packet end until the next packet start.
- Asserting n_rst mid-packet returns to the reset state immediately; no packet_done or rx_error is produced.

Decomposition:
- Package usb_rx_pkg: PID 4-bit constants, pkt_type enum, state enum, HS_LEN=1, TOKEN_LEN=3, CRC_BYTES=2.
- Bit counter: reuse the existing flex_counter (4-bit, rollover 8, clear on !receiving or packet start, count_enable = shift_enable & ~eop); its rollover_flag feeds byte completion.
- Byte counting, PID decode and FSM stay in usb_timer_rx.

Test Plan:
- ACK: 8 strobes with rx_byte=0xD2, then eop -> one byte_received; pid=0010, pkt_type=1; packet_done 1 cycle after eop; rx_error=0.
- IN token: 24 strobes (PID 0x69 plus 2 bytes), then eop -> 3 byte_received pulses; byte_count=3; packet_done.
- DATA0 (0xC3) with PAYLOAD_BYTES=32: 280 strobes, then eop -> 35 byte_received; pkt_type=3; packet_done; no error.
- Bad PID check: rx_byte=0xC2 on the first byte -> rx_error=1, pid=0; eop -> IDLE, no packet_done; the next receiving rise clears rx_error.
- Framing errors:
  - Early eop after 2 token bytes -> rx_error.
  - Eop after 20 bits -> rx_error.
  - A 4th token byte before eop (overrun) -> rx_error.
- Abort/corners:
  - receiving drops mid-DATA -> rx_error=1, IDLE.
  - eop coincident with shift_enable on a valid ACK -> packet_done, bit ignored.
  - n_rst asserted mid-packet -> all outputs 0 immediately.
